// File: rtl/aes_block_loader_if.sv
// Byte-stream ingress and block/key egress bundle for aes_block_loader.
// Master drives the byte stream and consumes blocks; slave is the loader.
interface aes_block_loader_if;
  logic [7:0]   s_data;
  logic         s_is_key;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] block_out;
  logic [127:0] key_out;
  logic         out_valid;
  logic         out_ready;
  logic         key_valid;
  logic [3:0]   byte_cnt;
  logic         err_no_key;

  modport master (
    output s_data, s_is_key, s_valid, out_ready,
    input  s_ready, block_out, key_out, out_valid,
    input  key_valid, byte_cnt, err_no_key
  );

  modport slave (
    input  s_data, s_is_key, s_valid, out_ready,
    output s_ready, block_out, key_out, out_valid,
    output key_valid, byte_cnt, err_no_key
  );
endinterface

// File: rtl/aes_block_loader.sv
// Byte-serial loader: assembles 16-byte key/plaintext groups into
// 128-bit words and holds them for the combinational AES-128 core.
module aes_block_loader #(
  parameter int BLOCK_BYTES = 16,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_block_loader_if.slave bus
);

  if (BLOCK_BYTES != 16) begin : g_bad_size
    $error("aes_block_loader supports only BLOCK_BYTES=16");
  end

  typedef enum logic {COLLECT, HOLD} state_e;

  state_e       state_q;
  logic [127:0] shadow_q;
  logic [127:0] shadow_d;
  logic [127:0] block_q;
  logic [127:0] key_q;
  logic [3:0]   cnt_q;
  logic         grp_key_q;
  logic         key_valid_q;
  logic         out_valid_q;
  logic         err_q;

  logic         accept;
  logic         grp_key;
  logic         drop;
  logic [3:0]   pos;

  assign accept  = bus.s_valid && (state_q == COLLECT);
  assign grp_key = (cnt_q == 4'd0) ? bus.s_is_key : grp_key_q;
  // Plaintext cannot start until a key exists; such bytes are swallowed.
  assign drop    = (cnt_q == 4'd0) && !bus.s_is_key && !key_valid_q;
  assign pos     = MSB_FIRST ? (4'd15 - cnt_q) : cnt_q;

  always_comb begin
    shadow_d = shadow_q;
    shadow_d[{pos, 3'b000} +: 8] = bus.s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      shadow_q    <= '0;
      block_q     <= '0;
      key_q       <= '0;
      cnt_q       <= '0;
      grp_key_q   <= 1'b0;
      key_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        COLLECT: begin
          if (accept) begin
            if (drop) begin
              err_q <= 1'b1;
            end else begin
              shadow_q  <= shadow_d;
              grp_key_q <= grp_key;
              cnt_q     <= cnt_q + 4'd1;
              if (cnt_q == 4'd15) begin
                if (grp_key) begin
                  key_q       <= shadow_d;
                  key_valid_q <= 1'b1;
                end else begin
                  block_q     <= shadow_d;
                  out_valid_q <= 1'b1;
                  state_q     <= HOLD;
                end
              end
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= COLLECT;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready    = (state_q == COLLECT);
  assign bus.block_out  = block_q;
  assign bus.key_out    = key_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.key_valid  = key_valid_q;
  assign bus.byte_cnt   = cnt_q;
  assign bus.err_no_key = err_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed + randomized bench for aes_block_loader against a group-level
// model of expected key/block words.
module tb_aes_block_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_block_loader_if bus();

  aes_block_loader dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  logic [127:0] exp_key;
  logic         exp_kv;
  logic [7:0]   b[16];
  logic [127:0] held_blk;
  logic [127:0] held_key;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // First byte of a group is the most significant byte of the word.
  function automatic logic [127:0] pack(input logic [7:0] v[16]);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++)
      r = r | (128'(v[k]) << (8 * (15 - k)));
    return r;
  endfunction

  task automatic rand_fill();
    for (int k = 0; k < 16; k++) b[k] = 8'($urandom);
  endtask

  // Present one byte (called at a negedge); returns at the negedge
  // after the accepting edge with s_valid low again.
  task automatic put(input logic [7:0] d, input logic k);
    int n;
    n = 0;
    bus.s_valid  = 1'b1;
    bus.s_data   = d;
    bus.s_is_key = k;
    while (bus.s_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.s_ready !== 1'b1)
      chk("put_timeout", {127'b0, bus.s_ready}, 128'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic group(input logic k);
    int gap;
    for (int i = 0; i < 16; i++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(negedge clk);
        chk("stall_cnt", 128'(bus.byte_cnt), 128'(i));
      end
      put(b[i], (i == 0) ? k : 1'($urandom));
      chk("byte_cnt", 128'(bus.byte_cnt), 128'((i + 1) % 16));
    end
    if (k) begin
      exp_key = pack(b);
      exp_kv  = 1'b1;
      chk("key_out", bus.key_out, exp_key);
      chk("key_valid", 128'(bus.key_valid), 128'd1);
      chk("kgrp_out_valid", 128'(bus.out_valid), 128'd0);
    end else begin
      chk("out_valid", 128'(bus.out_valid), 128'd1);
      chk("block_out", bus.block_out, pack(b));
      chk("blk_key_out", bus.key_out, exp_key);
    end
  endtask

  task automatic consume(input int hold);
    held_blk = bus.block_out;
    held_key = bus.key_out;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 128'(bus.out_valid), 128'd1);
      chk("hold_ready", 128'(bus.s_ready), 128'd0);
      chk("hold_blk", bus.block_out, held_blk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("consumed_valid", 128'(bus.out_valid), 128'd0);
    chk("consumed_ready", 128'(bus.s_ready), 128'd1);
    chk("consumed_key", bus.key_out, held_key);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.s_is_key  = 1'b0;
    bus.out_ready = 1'b0;
    exp_key = '0;
    exp_kv  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_key_valid", 128'(bus.key_valid), 128'd0);
    chk("rst_cnt", 128'(bus.byte_cnt), 128'd0);
    chk("rst_block", bus.block_out, 128'd0);
    chk("rst_key", bus.key_out, 128'd0);
    chk("rst_err", 128'(bus.err_no_key), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 128'(bus.s_ready), 128'd1);

    // Plaintext before any key: each byte dropped with an error pulse
    for (int i = 0; i < 3; i++) begin
      put(8'($urandom), 1'b0);
      chk("nokey_err", 128'(bus.err_no_key), 128'd1);
      chk("nokey_cnt", 128'(bus.byte_cnt), 128'd0);
      chk("nokey_kv", 128'(bus.key_valid), 128'd0);
      chk("nokey_ov", 128'(bus.out_valid), 128'd0);
      @(negedge clk);
      chk("nokey_err_end", 128'(bus.err_no_key), 128'd0);
    end

    // Known vector, out_ready already high
    for (int i = 0; i < 16; i++) b[i] = 8'(i);
    group(1'b1);
    chk("kat_key", bus.key_out, 128'h000102030405060708090a0b0c0d0e0f);
    for (int i = 0; i < 16; i++) b[i] = 8'(i * 17);
    bus.out_ready = 1'b1;
    group(1'b0);
    chk("kat_block", bus.block_out,
        128'h00112233445566778899aabbccddeeff);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("kat_one_cycle", 128'(bus.out_valid), 128'd0);
    chk("kat_ready_back", 128'(bus.s_ready), 128'd1);

    // Held block with key bytes pending on the stream
    rand_fill();
    group(1'b0);
    held_blk = bus.block_out;
    held_key = bus.key_out;
    bus.s_valid  = 1'b1;
    bus.s_is_key = 1'b1;
    bus.s_data   = 8'haa;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", 128'(bus.s_ready), 128'd0);
      chk("bp_blk", bus.block_out, held_blk);
      chk("bp_key", bus.key_out, held_key);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.s_valid   = 1'b0;
    chk("bp_released", 128'(bus.s_ready), 128'd1);
    chk("bp_no_accept", 128'(bus.byte_cnt), 128'd0);
    chk("bp_ov_low", 128'(bus.out_valid), 128'd0);

    // Two blocks under the old key, then a rekey and a third block
    rand_fill(); group(1'b0); consume($urandom_range(0, 3));
    rand_fill(); group(1'b0); consume($urandom_range(0, 3));
    for (int i = 0; i < 16; i++) b[i] = 8'(255 - i);
    group(1'b1);
    chk("rekey", bus.key_out, 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0);
    rand_fill(); group(1'b0); consume(1);

    // Stall for 3 cycles after byte 7
    rand_fill();
    for (int i = 0; i < 8; i++) put(b[i], (i == 0) ? 1'b0 : 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("stall8", 128'(bus.byte_cnt), 128'd8);
    end
    for (int i = 8; i < 16; i++) put(b[i], 1'($urandom));
    chk("stall_ov", 128'(bus.out_valid), 128'd1);
    chk("stall_blk", bus.block_out, pack(b));
    consume(0);

    // Random mix of key and plaintext groups
    repeat (6) begin
      rand_fill();
      if ($urandom_range(0, 2) == 0) begin
        group(1'b1);
      end else begin
        group(1'b0);
        consume($urandom_range(0, 4));
      end
    end

    // Asynchronous reset after byte 9 of a key group
    rand_fill();
    for (int i = 0; i < 10; i++) put(b[i], 1'b1);
    chk("pre_rst_cnt", 128'(bus.byte_cnt), 128'd10);
    #2 rst_n = 1'b0;
    #1;
    exp_key = '0;
    exp_kv  = 1'b0;
    chk("arst_cnt", 128'(bus.byte_cnt), 128'd0);
    chk("arst_key", bus.key_out, exp_key);
    chk("arst_kv", 128'(bus.key_valid), 128'(exp_kv));
    chk("arst_blk", bus.block_out, 128'd0);
    chk("arst_ov", 128'(bus.out_valid), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    put(8'h5a, 1'b0);
    chk("post_rst_err", 128'(bus.err_no_key), 128'd1);
    chk("post_rst_cnt", 128'(bus.byte_cnt), 128'd0);
    chk("post_rst_kv", 128'(bus.key_valid), 128'd0);
    rand_fill(); group(1'b1);
    rand_fill(); group(1'b0); consume(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
